nw_vc_credit_tracker: RTL and testbench

//  Output-port credit and VC-status tracker; one per router output port.

---
 rtl/nw_vc_credit_tracker_pkg.sv | 40 ++++
 rtl/nw_vc_credit_tracker_ctr.sv | 81 ++++++++
 rtl/nw_vc_credit_tracker.sv | 76 +++++++
 tb/tb_nw_vc_credit_tracker.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nw_vc_credit_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nw_vc_credit_tracker_pkg
// Brief    : Shared types, sizing helpers and VC state encoding for the
//            output-port credit tracker (NW_functions).
// Revision : 1.0 - initial release
// ============================================================================
package nw_vc_credit_tracker_pkg;

  // Ceiling log2 with a floor of one bit, so a single-entry field still exists.
  function automatic int clogb2(input int value);
    int w;
    w = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      w++;
    end
    return (w < 1) ? 1 : w;
  endfunction

  localparam int NW_N         = 4;
  localparam int NW_BUF_DEPTH = 3;
  localparam int NW_VC_W      = clogb2(NW_N);
  localparam int NW_CNT_W     = clogb2(NW_BUF_DEPTH + 1);

  typedef logic [NW_VC_W-1:0]  vc_index_t;
  typedef logic [NW_CNT_W-1:0] credit_cnt_t;

  // Raw encodings kept as sized constants for legacy code that compares bits.
  localparam logic [1:0] ST_FREE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  typedef enum logic [1:0] {
    FREE   = ST_FREE,
    ACTIVE = ST_ACTIVE,
    DRAIN  = ST_DRAIN
  } vc_state_t;

endpackage
`default_nettype wire

// File: rtl/nw_vc_credit_tracker_ctr.sv
`default_nettype none
// ============================================================================
// Module   : nw_vc_credit_ctr
// Brief    : Credit counter plus FREE/ACTIVE/DRAIN state machine for one
//            downstream virtual channel. Optional protocol checking is
//            compiled in with NW_CREDIT_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module nw_vc_credit_ctr
  import nw_vc_credit_tracker_pkg::*;
#(
  parameter int BUF_DEPTH = NW_BUF_DEPTH,
  parameter int CW        = clogb2(BUF_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dec,
  input  logic          inc,
  input  logic          tail,
  input  logic          alloc,
`ifdef NW_CREDIT_ERR_EN
  output logic          proto_err,
`endif
  output logic [CW-1:0] cnt,
  output logic          free,
  output logic          has_credit
);

  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  logic [CW-1:0] cnt_next;
  vc_state_t     state;
  vc_state_t     state_next;

  // Saturating credit update; a simultaneous send and return cancel out.
  always_comb begin
    cnt_next = cnt;
    if (dec && !inc && (cnt != '0)) begin
      cnt_next = cnt - 1'b1;
    end else if (inc && !dec && (cnt != FULL)) begin
      cnt_next = cnt + 1'b1;
    end
  end

  // VC lifecycle; DRAIN looks at the post-update count so the last credit frees it.
  always_comb begin
    state_next = state;
    case (state)
      FREE:    if (alloc)       state_next = ACTIVE;
      ACTIVE:  if (dec && tail) state_next = DRAIN;
      DRAIN:   if (cnt_next == FULL) state_next = FREE;
      default: state_next = FREE;
    endcase
  end

  // Counter and state registers, cleared to a full, free VC on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= FULL;
      state <= FREE;
    end else begin
      cnt   <= cnt_next;
      state <= state_next;
    end
  end

  assign free       = (state == FREE);
  assign has_credit = (cnt != '0);

`ifdef NW_CREDIT_ERR_EN
  // Flags underflow, overflow, re-allocation of a busy VC and sending on a non-ACTIVE VC.
  always_comb begin
    proto_err = (dec && !inc && (cnt == '0))
              | (inc && !dec && (cnt == FULL))
              | (alloc && (state != FREE))
              | (dec && (state != ACTIVE));
  end
`endif

endmodule
`default_nettype wire

// File: rtl/nw_vc_credit_tracker.sv
`default_nettype none
// ============================================================================
// Module   : nw_vc_credit_tracker
// Brief    : Per-output-port credit and VC status tracker. Mirrors downstream
//            VC buffer occupancy, reports free VCs to the VC allocator and
//            credit availability to the switch allocator.
//            Macro NW_CREDIT_ERR_EN enables the sticky protocol-error flag.
// Revision : 1.0 - initial release
// ============================================================================
module nw_vc_credit_tracker
  import nw_vc_credit_tracker_pkg::*;
#(
  parameter int N         = NW_N,
  parameter int BUF_DEPTH = NW_BUF_DEPTH,
  parameter int VC_W      = clogb2(N),
  parameter int CW        = clogb2(BUF_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flit_valid,
  input  logic [VC_W-1:0] flit_vc,
  input  logic            flit_tail,
  input  logic            credit_valid,
  input  logic [VC_W-1:0] credit_vc,
  input  logic [N-1:0]    vc_alloc,
  output logic [N-1:0]    vc_free,
  output logic [N-1:0]    vc_has_credit,
  output logic [N*CW-1:0] credit_cnt,
  output logic            err
);

`ifdef NW_CREDIT_ERR_EN
  logic [N-1:0] vc_err;
`endif

  for (genvar i = 0; i < N; i++) begin : g_vc
    logic dec;
    logic inc;

    assign dec = flit_valid   && (flit_vc   == VC_W'(i));
    assign inc = credit_valid && (credit_vc == VC_W'(i));

    nw_vc_credit_ctr #(
      .BUF_DEPTH (BUF_DEPTH),
      .CW        (CW)
    ) u_ctr (
      .clk        (clk),
      .rst_n      (rst_n),
      .dec        (dec),
      .inc        (inc),
      .tail       (flit_tail),
      .alloc      (vc_alloc[i]),
`ifdef NW_CREDIT_ERR_EN
      .proto_err  (vc_err[i]),
`endif
      .cnt        (credit_cnt[i*CW +: CW]),
      .free       (vc_free[i]),
      .has_credit (vc_has_credit[i])
    );
  end

`ifdef NW_CREDIT_ERR_EN
  // Sticky error: any per-VC violation latches until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (|vc_err) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nw_vc_credit_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_nw_vc_credit_tracker
// Brief    : Self-checking bench for nw_vc_credit_tracker (n=4, depth=3).
//            Expected outputs are queued per driven cycle and compared after
//            the following clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nw_vc_credit_tracker;

  localparam int N  = 4;
  localparam int D  = 3;
  localparam int CW = 2;
`ifdef NW_CREDIT_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flit_valid;
  logic [1:0]      flit_vc;
  logic            flit_tail;
  logic            credit_valid;
  logic [1:0]      credit_vc;
  logic [N-1:0]    vc_alloc;
  logic [N-1:0]    vc_free;
  logic [N-1:0]    vc_has_credit;
  logic [N*CW-1:0] credit_cnt;
  logic            err;

  always #5 clk = ~clk;

  nw_vc_credit_tracker dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flit_valid    (flit_valid),
    .flit_vc       (flit_vc),
    .flit_tail     (flit_tail),
    .credit_valid  (credit_valid),
    .credit_vc     (credit_vc),
    .vc_alloc      (vc_alloc),
    .vc_free       (vc_free),
    .vc_has_credit (vc_has_credit),
    .credit_cnt    (credit_cnt),
    .err           (err)
  );

  typedef struct packed {
    logic [7:0] cnt;
    logic [3:0] free;
    logic [3:0] hc;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   m_cnt[N];
  int   m_st[N];   // 0 free, 1 active, 2 drain
  logic m_err;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.cnt[i*2 +: 2] = 2'(m_cnt[i]);
      e.free[i]       = (m_st[i] == 0);
      e.hc[i]         = (m_cnt[i] != 0);
    end
    e.err = m_err;
    return e;
  endfunction

  task automatic model_step(input logic fv, input int fvc, input logic ft, input logic cv,
                            input int cvc, input logic [3:0] al, input logic rstn);
    logic any_err;
    logic d;
    logic c;
    int   nc;
    any_err = 1'b0;
    if (!rstn) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[i] = D;
        m_st[i]  = 0;
      end
      m_err = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        d  = fv && (fvc == i);
        c  = cv && (cvc == i);
        nc = m_cnt[i];
        if (d && !c) begin
          if (m_cnt[i] == 0) any_err = 1'b1;
          else nc = m_cnt[i] - 1;
        end else if (c && !d) begin
          if (m_cnt[i] == D) any_err = 1'b1;
          else nc = m_cnt[i] + 1;
        end
        if (al[i] && m_st[i] != 0) any_err = 1'b1;
        if (d && m_st[i] != 1) any_err = 1'b1;
        case (m_st[i])
          0: if (al[i]) m_st[i] = 1;
          1: if (d && ft) m_st[i] = 2;
          2: if (nc == D) m_st[i] = 0;
          default: m_st[i] = 0;
        endcase
        m_cnt[i] = nc;
      end
      if (ERR_ON && any_err) m_err = 1'b1;
    end
  endtask

  // Drive one cycle of stimulus, queue the model's prediction, then compare.
  task automatic step(input logic fv, input int fvc, input logic ft, input logic cv,
                      input int cvc, input logic [3:0] al, input logic rstn);
    exp_t e;
    rst_n        = rstn;
    flit_valid   = fv;
    flit_vc      = 2'(fvc);
    flit_tail    = ft;
    credit_valid = cv;
    credit_vc    = 2'(cvc);
    vc_alloc     = al;
    model_step(fv, fvc, ft, cv, cvc, al, rstn);
    sb_q.push_back(model_outputs());
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_val("credit_cnt",    32'(credit_cnt),    32'(e.cnt));
      check_val("vc_free",       32'(vc_free),       32'(e.free));
      check_val("vc_has_credit", 32'(vc_has_credit), 32'(e.hc));
      check_val("err",           32'(err),           32'(e.err));
    end
  endtask

  task automatic do_reset();
    step(1'b0, 0, 1'b0, 1'b0, 0, 4'b0000, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 0, 1'b0, 1'b0, 0, 4'b0000, 1'b1);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_cnt"},  32'(credit_cnt),    32'h0000_00FF);
    check_val({tag, "_free"}, 32'(vc_free),       32'h0000_000F);
    check_val({tag, "_hc"},   32'(vc_has_credit), 32'h0000_000F);
    check_val({tag, "_err"},  32'(err),           32'h0);
  endtask

  initial begin
    rst_n = 1'b0; flit_valid = 1'b0; flit_vc = '0; flit_tail = 1'b0;
    credit_valid = 1'b0; credit_vc = '0; vc_alloc = '0;
    @(posedge clk);
    #1;

    // 1: reset state
    do_reset();
    check_reset_state("s1_reset");
    idle();

    // 2: three flits drain VC1, the fourth underflows
    do_reset();
    step(1'b0, 0, 1'b0, 1'b0, 0, 4'b0010, 1'b1);
    step(1'b1, 1, 1'b0, 1'b0, 0, 4'b0000, 1'b1);
    check_val("s2_cnt1_a", 32'(credit_cnt[3:2]), 32'd2);
    step(1'b1, 1, 1'b0, 1'b0, 0, 4'b0000, 1'b1);
    check_val("s2_cnt1_b", 32'(credit_cnt[3:2]), 32'd1);
    step(1'b1, 1, 1'b0, 1'b0, 0, 4'b0000, 1'b1);
    check_val("s2_cnt1_c", 32'(credit_cnt[3:2]), 32'd0);
    check_val("s2_hc1",    32'(vc_has_credit[1]), 32'd0);
    check_val("s2_err_pre", 32'(err), 32'd0);
    step(1'b1, 1, 1'b0, 1'b0, 0, 4'b0000, 1'b1);
    check_val("s2_cnt1_sat", 32'(credit_cnt[3:2]), 32'd0);
    check_val("s2_err",      32'(err), 32'(ERR_ON));

    // 3: simultaneous send and return on VC2
    do_reset();
    step(1'b0, 0, 1'b0, 1'b0, 0, 4'b0100, 1'b1);
    step(1'b1, 2, 1'b0, 1'b0, 0, 4'b0000, 1'b1);
    step(1'b1, 2, 1'b0, 1'b1, 2, 4'b0000, 1'b1);
    check_val("s3_cnt2", 32'(credit_cnt[5:4]), 32'd2);
    check_val("s3_err",  32'(err), 32'd0);

    // 4: VC0 packet, drain and free on the final credit
    do_reset();
    step(1'b0, 0, 1'b0, 1'b0, 0, 4'b0001, 1'b1);
    check_val("s4_free0_active", 32'(vc_free[0]), 32'd0);
    step(1'b1, 0, 1'b0, 1'b0, 0, 4'b0000, 1'b1);
    step(1'b1, 0, 1'b1, 1'b0, 0, 4'b0000, 1'b1);
    check_val("s4_cnt0_drain", 32'(credit_cnt[1:0]), 32'd1);
    check_val("s4_free0_drain", 32'(vc_free[0]), 32'd0);
    step(1'b0, 0, 1'b0, 1'b1, 0, 4'b0000, 1'b1);
    check_val("s4_free0_1st", 32'(vc_free[0]), 32'd0);
    step(1'b0, 0, 1'b0, 1'b1, 0, 4'b0000, 1'b1);
    check_val("s4_free0_2nd", 32'(vc_free[0]), 32'd1);
    check_val("s4_cnt0_full", 32'(credit_cnt[1:0]), 32'd3);
    check_val("s4_err", 32'(err), 32'd0);

    // 5: re-allocating an ACTIVE VC3 is ignored and flagged
    do_reset();
    step(1'b0, 0, 1'b0, 1'b0, 0, 4'b1000, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0, 0, 4'b1000, 1'b1);
    check_val("s5_free3", 32'(vc_free[3]), 32'd0);
    check_val("s5_err",   32'(err), 32'(ERR_ON));
    step(1'b1, 3, 1'b1, 1'b0, 0, 4'b0000, 1'b1);
    check_val("s5_cnt3", 32'(credit_cnt[7:6]), 32'd2);

    // 6: reset in the middle of DRAIN with one credit left
    do_reset();
    step(1'b0, 0, 1'b0, 1'b0, 0, 4'b0001, 1'b1);
    step(1'b1, 0, 1'b0, 1'b0, 0, 4'b0000, 1'b1);
    step(1'b1, 0, 1'b1, 1'b0, 0, 4'b0000, 1'b1);
    check_val("s6_cnt0_pre", 32'(credit_cnt[1:0]), 32'd1);
    do_reset();
    check_reset_state("s6_reset");

    // Random traffic including illegal cases, checked against the model
    for (int k = 0; k < 80; k++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           ($urandom_range(0, 2) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000,
           ($urandom_range(0, 39) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
